// File: rtl/idex_skid_stage.sv
// ID/EX pipeline stage: valid/ready handshake with a one-entry skid buffer and flush-to-bubble.
// Optional performance counters are enabled by defining IDEX_PERF_CNT_EN.
module idex_skid_stage #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int CTRL_W = 11,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_pc4,
  input  logic [DATA_W-1:0] in_rs_data,
  input  logic [DATA_W-1:0] in_rt_data,
  input  logic [DATA_W-1:0] in_imm,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_pc4,
  output logic [DATA_W-1:0] out_rs_data,
  output logic [DATA_W-1:0] out_rt_data,
  output logic [DATA_W-1:0] out_imm,
  output logic [REG_AW-1:0] out_rs,
  output logic [REG_AW-1:0] out_rt,
  output logic [REG_AW-1:0] out_rd,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  localparam int BW = CTRL_W + 4*DATA_W + 3*REG_AW;

  logic [BW-1:0]     w_in, r_main, r_skid;
  logic [CTRL_W-1:0] w_main_ctrl;
  logic              r_main_valid, r_skid_valid;
  logic              w_accept, w_drain, w_load_main;

  assign w_in = {in_ctrl, in_pc4, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd};
  assign {w_main_ctrl, out_pc4, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd} = r_main;

  // Ready depends only on registered state so EX back-pressure never reaches ID combinationally.
  assign in_ready    = ~r_skid_valid & ~rst;
  assign out_valid   = r_main_valid;
  assign out_ctrl    = r_main_valid ? w_main_ctrl : '0;
  assign w_accept    = in_valid & in_ready;
  assign w_drain     = r_main_valid & out_ready;
  assign w_load_main = ~r_main_valid | w_drain;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_main       <= '0;
    end else if (flush) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
    end else if (w_load_main) begin
      // A full skid forces in_ready low, so skid and a new beat never compete for main.
      r_main_valid <= r_skid_valid | w_accept;
      r_skid_valid <= 1'b0;
      if (r_skid_valid)  r_main <= r_skid;
      else if (w_accept) r_main <= w_in;
    end else if (w_accept) begin
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept && !w_load_main) r_skid <= w_in;
  end

`ifdef IDEX_PERF_CNT_EN
  logic [CNT_W-1:0] r_stall, r_bubble, r_flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall  <= '0;
      r_bubble <= '0;
      r_flush  <= '0;
    end else begin
      if (r_main_valid && !out_ready && r_stall != '1) r_stall <= r_stall + CNT_W'(1);
      if (!r_main_valid && r_bubble != '1)             r_bubble <= r_bubble + CNT_W'(1);
      if (flush && (r_main_valid || r_skid_valid) && r_flush != '1)
        r_flush <= r_flush + CNT_W'(1);
    end
  end

  assign stall_cnt  = r_stall;
  assign bubble_cnt = r_bubble;
  assign flush_cnt  = r_flush;
`else
  assign stall_cnt  = '0;
  assign bubble_cnt = '0;
  assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_idex_skid_stage.sv
// Scoreboard bench for idex_skid_stage: the stage is modelled as an in-order FIFO of at most two beats.
// Counter checks follow IDEX_PERF_CNT_EN (CNT_W=4 so saturation is reachable).
module tb_idex_skid_stage;
  localparam int DW = 32, AW = 5, CW = 11, NW = 4;

  typedef struct packed {
    logic [CW-1:0] ctrl;
    logic [DW-1:0] pc4, rs_data, rt_data, imm;
    logic [AW-1:0] rs, rt, rd;
  } beat_t;

  logic clk = 1'b0;
  logic rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_pc4, in_rs_data, in_rt_data, in_imm;
  logic [DW-1:0] out_pc4, out_rs_data, out_rt_data, out_imm;
  logic [AW-1:0] in_rs, in_rt, in_rd, out_rs, out_rt, out_rd;
  logic [NW-1:0] stall_cnt, bubble_cnt, flush_cnt;

  idex_skid_stage #(.DATA_W(DW), .REG_AW(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_pc4(in_pc4), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_imm(in_imm), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .out_valid(out_valid), .out_ready(out_ready), .out_ctrl(out_ctrl), .out_pc4(out_pc4),
    .out_rs_data(out_rs_data), .out_rt_data(out_rt_data), .out_imm(out_imm),
    .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  int    total = 0, bad = 0;
  bit    started = 1'b0, taken = 1'b0;
  beat_t q[$];
  logic [NW-1:0] m_stall = '0, m_bubble = '0, m_flush = '0;

  function automatic void chk(string nm, logic [159:0] act, logic [159:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endfunction

  function automatic logic [NW-1:0] sat_inc(logic [NW-1:0] v, bit c);
    return (c && v != '1) ? v + NW'(1) : v;
  endfunction

  // Monitor: outputs and inputs are stable here; check against the model, then advance it.
  always @(negedge clk) begin
    if (started) begin
      bit    exp_ready, acc;
      beat_t act, cur;
      exp_ready = !rst && q.size() < 2;
      act = {out_ctrl, out_pc4, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd};
      cur = {in_ctrl, in_pc4, in_rs_data, in_rt_data, in_imm, in_rs, in_rt, in_rd};
      chk("in_ready", 160'(in_ready), 160'(exp_ready));
      chk("out_valid", 160'(out_valid), 160'(q.size() > 0));
      if (q.size() > 0) chk("out_beat", 160'(act), 160'(q[0]));
      else              chk("bubble_ctrl", 160'(out_ctrl), 160'(0));
`ifdef IDEX_PERF_CNT_EN
      chk("stall_cnt", 160'(stall_cnt), 160'(m_stall));
      chk("bubble_cnt", 160'(bubble_cnt), 160'(m_bubble));
      chk("flush_cnt", 160'(flush_cnt), 160'(m_flush));
`else
      chk("cnt_zero", 160'({stall_cnt, bubble_cnt, flush_cnt}), 160'(0));
`endif
      taken = in_valid && exp_ready;
      acc   = taken && !flush;
      if (rst) begin
        m_stall = '0; m_bubble = '0; m_flush = '0;
      end else begin
        m_stall  = sat_inc(m_stall, q.size() > 0 && !out_ready);
        m_bubble = sat_inc(m_bubble, q.size() == 0);
        m_flush  = sat_inc(m_flush, flush && q.size() > 0);
      end
      if (rst || flush) q.delete();
      else begin
        if (q.size() > 0 && out_ready) void'(q.pop_front());
        if (acc) q.push_back(cur);
      end
    end
  end

  task automatic ctl(bit v, bit ro, bit fl, bit r);
    @(posedge clk); #1;
    in_valid = v; out_ready = ro; flush = fl; rst = r;
  endtask

  task automatic drv(bit v, logic [DW-1:0] pc, logic [CW-1:0] c, bit ro, bit fl, bit r);
    @(posedge clk); #1;
    in_valid = v; out_ready = ro; flush = fl; rst = r;
    in_pc4 = pc; in_ctrl = c;
    in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
    in_rs = AW'($urandom); in_rt = AW'($urandom); in_rd = AW'($urandom);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_pc4 = '0; in_rs_data = '0; in_rt_data = '0; in_imm = '0;
    in_rs = '0; in_rt = '0; in_rd = '0;
    @(posedge clk); started = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rst_data", 160'({out_pc4, out_rs_data, out_rt_data, out_imm, out_rs, out_rt, out_rd}), 160'(0));

    // Back-to-back stream.
    for (int i = 1; i <= 10; i++) drv(1, DW'(4*i), CW'($urandom), 1, 0, 0);
    drv(0, 0, 0, 1, 0, 0);
    ctl(0, 1, 0, 0);

    // Fill main and skid, hold C, then release.
    drv(1, 32'h100, CW'($urandom), 0, 0, 0);
    drv(1, 32'h104, CW'($urandom), 0, 0, 0);
    drv(1, 32'h108, CW'($urandom), 0, 0, 0);
    ctl(1, 1, 0, 0);
    ctl(1, 1, 0, 0);
    ctl(0, 1, 0, 0);
    ctl(0, 1, 0, 0);

    // Flush with skid full and a beat offered.
    drv(1, 32'h200, CW'($urandom), 0, 0, 0);
    drv(1, 32'h204, CW'($urandom), 0, 0, 0);
    drv(1, 32'h208, CW'($urandom), 0, 1, 0);
    ctl(0, 1, 0, 0);
    ctl(0, 1, 0, 0);

    // Flush and reset together, then an all-ones control beat followed by a bubble.
    drv(1, 32'h300, CW'($urandom), 0, 1, 1);
    drv(1, 32'h304, 11'h7FF, 1, 0, 0);
    ctl(0, 1, 0, 0);
    ctl(0, 1, 0, 0);

    // Long stall with main valid.
    ctl(0, 0, 0, 1);
    drv(1, 32'h400, CW'($urandom), 0, 0, 0);
    for (int i = 0; i < 20; i++) ctl(0, 0, 0, 0);
    @(negedge clk);
`ifdef IDEX_PERF_CNT_EN
    chk("stall_sat", 160'(stall_cnt), 160'(15));
`else
    chk("stall_off", 160'(stall_cnt), 160'(0));
`endif
    ctl(0, 1, 0, 0);

    // Randomised traffic; an offered-but-untaken beat is held stable.
    for (int i = 0; i < 800; i++) begin
      bit keep;
      keep = in_valid && !taken;
      if (keep)
        ctl(1, ($urandom % 10) < 6, ($urandom % 40) == 0, ($urandom % 150) == 0);
      else
        drv(($urandom % 10) < 7, $urandom, CW'($urandom), ($urandom % 10) < 6,
            ($urandom % 40) == 0, ($urandom % 150) == 0);
    end
    ctl(0, 1, 0, 0);
    ctl(0, 1, 0, 0);
    @(negedge clk);
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
